// File: rtl/mem_streams_sched.sv
// mem_streams_sched: write framing and read-burst scheduler for the mem_streams
// FIFO bank. Incoming words are framed into SYM_LEN-word symbols and written at a
// free-running bank address; whole buffered symbols are released downstream as
// SYM_LEN-cycle read bursts separated by GAP_CYC idle cycles.
module mem_streams_sched #(
  parameter  int ADDR_WIDTH = 11,
  parameter  int SYM_LEN    = 396,
  parameter  int GAP_CYC    = 4,
  localparam int MAX_SYM    = (2 ** ADDR_WIDTH) / SYM_LEN,
  localparam int CW         = $clog2(MAX_SYM + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_in_vld,
  input  logic                  i_in_sop,
  input  logic                  i_rd_ready,
  output logic                  o_wr_wen,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_ren,
  output logic                  o_rvalid,
  output logic                  o_sym_last,
  output logic [CW-1:0]         o_avail,
  output logic [CW-1:0]         o_occ,
  output logic                  o_overflow,
  output logic [15:0]           o_drop_cnt
);

  localparam int WCW = $clog2(SYM_LEN);
  localparam int RMX = (SYM_LEN > GAP_CYC) ? SYM_LEN : GAP_CYC;
  localparam int RCW = $clog2(RMX + 1);

  localparam logic [WCW-1:0] WLAST = WCW'(SYM_LEN - 1);
  localparam logic [RCW-1:0] RLAST = RCW'(SYM_LEN - 1);
  localparam logic [RCW-1:0] GLAST = RCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CW-1:0]  MAXC  = CW'(MAX_SYM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Write-side state
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic                  wr_wen_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  overflow_q;
  logic [15:0]           drop_cnt_q;

  // Symbol bookkeeping
  logic [CW-1:0] avail_q, avail_d;
  logic [CW-1:0] occ_q, occ_d;

  // Read FSM
  state_t         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           rd_ren, sym_last, launch;

  logic word0, room, acc_now, wr_fire, last_word, commit, drop;

  // Framing: locate word 0, decide admission there, and flag the committing word.
  always_comb begin
    word0     = i_in_sop | (wcnt_q == '0);
    room      = (occ_q < MAXC);
    acc_now   = word0 ? room : acc_q;
    wr_fire   = i_in_vld & acc_now;
    last_word = ~i_in_sop & (wcnt_q == WLAST);
    commit    = wr_fire & last_word;
    drop      = i_in_vld & word0 & ~room;
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    if (i_in_vld) begin
      if (i_in_sop)            wcnt_d = WCW'(1);
      else if (wcnt_q == WLAST) wcnt_d = '0;
      else                     wcnt_d = wcnt_q + WCW'(1);
      if (word0)               acc_d  = room;
    end
  end

  // Write-side registers: word counter, address pointer, bank write strobe, drop stats.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wcnt_q     <= '0;
      acc_q      <= 1'b0;
      wr_ptr_q   <= '0;
      wr_wen_q   <= 1'b0;
      wr_addr_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      acc_q    <= acc_d;
      wr_wen_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= wr_ptr_q;
        wr_ptr_q  <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Read FSM next state; the cycle counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if ((avail_q != '0) && i_rd_ready) state_d = S_READ;
      S_READ: if (rcnt_q == RLAST) state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (rcnt_q == GLAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_d != state_q) || (state_q == S_IDLE)) rcnt_d = '0;
    else                                             rcnt_d = rcnt_q + RCW'(1);
  end

  // Read FSM outputs: burst window, last-cycle pulse and launch strobe.
  always_comb begin
    rd_ren   = (state_q == S_READ);
    sym_last = rd_ren & (rcnt_q == RLAST);
    launch   = (state_q == S_IDLE) & (avail_q != '0) & i_rd_ready;
  end

  // Symbol counters; a simultaneous increment and decrement cancel out.
  always_comb begin
    avail_d = avail_q;
    occ_d   = occ_q;
    if (commit && !launch)   avail_d = avail_q + CW'(1);
    if (!commit && launch)   avail_d = avail_q - CW'(1);
    if (commit && !sym_last) occ_d   = occ_q + CW'(1);
    if (!commit && sym_last) occ_d   = occ_q - CW'(1);
  end

  // Symbol counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      avail_q <= '0;
      occ_q   <= '0;
    end else begin
      avail_q <= avail_d;
      occ_q   <= occ_d;
    end
  end

  assign o_wr_wen   = wr_wen_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_rd_ren   = rd_ren;
  assign o_rvalid   = rd_ren;
  assign o_sym_last = sym_last;
  assign o_avail    = avail_q;
  assign o_occ      = occ_q;
  assign o_overflow = overflow_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mem_streams_sched.sv
// Bench for mem_streams_sched with SYM_LEN=8, ADDR_WIDTH=5 (MAX_SYM=4), GAP_CYC=2.
module tb_mem_streams_sched;

  localparam int AW = 5;
  localparam int SL = 8;
  localparam int GC = 2;
  localparam int CW = 3;
  localparam int SPACING = SL + GC + 1;

  logic          clk = 1'b0;
  logic          rst, vld, sop, rdy;
  logic          o_wr_wen, o_rd_ren, o_rvalid, o_sym_last, o_overflow;
  logic [AW-1:0] o_wr_addr;
  logic [CW-1:0] o_avail, o_occ;
  logic [15:0]   o_drop_cnt;

  always #5 clk = ~clk;

  mem_streams_sched #(.ADDR_WIDTH(AW), .SYM_LEN(SL), .GAP_CYC(GC)) dut (
    .i_clk(clk), .i_reset(rst), .i_in_vld(vld), .i_in_sop(sop), .i_rd_ready(rdy),
    .o_wr_wen(o_wr_wen), .o_wr_addr(o_wr_addr), .o_rd_ren(o_rd_ren),
    .o_rvalid(o_rvalid), .o_sym_last(o_sym_last), .o_avail(o_avail), .o_occ(o_occ),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    logic          vld, sop, rdy;
    logic          wen;
    logic [AW-1:0] addr;
    logic [CW-1:0] avail, occ;
    logic          ren, last;
  } vec_t;

  vec_t tbl[19];

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [AW-1:0] wq[$];
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] sb_e;
  bit            sb_en = 1'b0;
  int            rises[$];
  int            last_cnt = 0;
  int            run = 0;
  logic          prev_ren = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: write-address scoreboard and burst-shape observer.
  always @(negedge clk) begin
    if (sb_en && o_wr_wen) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: write at addr %0d, none expected", o_wr_addr);
      end else begin
        sb_e = wq.pop_front();
        chk("wr_addr", int'(o_wr_addr), int'(sb_e));
      end
    end
    if (o_rd_ren && !prev_ren) rises.push_back(cyc);
    if (o_sym_last) begin
      last_cnt <= last_cnt + 1;
      chk("sym_last_pos", run + 1, SL);
      chk("sym_last_ren", int'(o_rd_ren), 1);
    end
    run      <= o_rd_ren ? run + 1 : 0;
    prev_ren <= o_rd_ren;
  end

  function automatic vec_t mk(input logic v, input logic s, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [CW-1:0] av,
                              input logic [CW-1:0] oc, input logic rn, input logic l);
    vec_t t;
    t.vld = v; t.sop = s; t.rdy = r; t.wen = w; t.addr = a;
    t.avail = av; t.occ = oc; t.ren = rn; t.last = l;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic s, input bit acc);
    vld = 1'b1;
    sop = s;
    if (acc) begin
      wq.push_back(exp_addr);
      exp_addr = exp_addr + 1'b1;
    end
    tick();
    vld = 1'b0;
    sop = 1'b0;
  endtask

  task automatic send_sym(input bit acc);
    for (int i = 0; i < SL; i++) send_word(i == 0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; sop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    wq.delete();
    exp_addr = '0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((o_occ != '0 || o_rd_ren) && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(o_occ), 0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_wen"},   int'(o_wr_wen),   0);
    chk({pfx, "_addr"},  int'(o_wr_addr),  0);
    chk({pfx, "_ren"},   int'(o_rd_ren),   0);
    chk({pfx, "_rvld"},  int'(o_rvalid),   0);
    chk({pfx, "_last"},  int'(o_sym_last), 0);
    chk({pfx, "_avail"}, int'(o_avail),    0);
    chk({pfx, "_occ"},   int'(o_occ),      0);
    chk({pfx, "_ovf"},   int'(o_overflow), 0);
    chk({pfx, "_drops"}, int'(o_drop_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int r0, lc, n;

    // Single symbol timeline from reset: row i drives cycle i, expects cycle i+1.
    for (int i = 0; i < 7; i++)
      tbl[i] = mk(1'b1, i == 0, 1'b1, 1'b1, AW'(i), 3'd0, 3'd0, 1'b0, 1'b0);
    tbl[7] = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 3'd1, 3'd1, 1'b0, 1'b0);
    for (int i = 8; i < 15; i++)
      tbl[i] = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 3'd0, 3'd1, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 3'd0, 3'd1, 1'b1, 1'b1);
    for (int i = 16; i < 19; i++)
      tbl[i] = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 3'd0, 3'd0, 1'b0, 1'b0);

    rst = 1'b1; vld = 1'b0; sop = 1'b0; rdy = 1'b0; exp_addr = '0;
    tick(); tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      vld = tbl[i].vld; sop = tbl[i].sop; rdy = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_wen", i),   int'(o_wr_wen),   int'(tbl[i].wen));
      chk($sformatf("tbl%0d_addr", i),  int'(o_wr_addr),  int'(tbl[i].addr));
      chk($sformatf("tbl%0d_avail", i), int'(o_avail),    int'(tbl[i].avail));
      chk($sformatf("tbl%0d_occ", i),   int'(o_occ),      int'(tbl[i].occ));
      chk($sformatf("tbl%0d_ren", i),   int'(o_rd_ren),   int'(tbl[i].ren));
      chk($sformatf("tbl%0d_rvld", i),  int'(o_rvalid),   int'(tbl[i].ren));
      chk($sformatf("tbl%0d_last", i),  int'(o_sym_last), int'(tbl[i].last));
    end
    vld = 1'b0; sop = 1'b0; rdy = 1'b0;
    sb_en = 1'b1;

    // Back-to-back symbols with downstream always ready.
    do_reset();
    rdy = 1'b1;
    r0 = rises.size();
    repeat (3) send_sym(1'b1);
    wait_drain(80, "b2b_drain");
    chk("b2b_bursts", rises.size() - r0, 3);
    if (rises.size() >= r0 + 3) begin
      chk("b2b_space1", rises[r0 + 1] - rises[r0], SPACING);
      chk("b2b_space2", rises[r0 + 2] - rises[r0 + 1], SPACING);
    end
    chk("b2b_avail", int'(o_avail), 0);

    // Overflow: four symbols fill the bank, the fifth is dropped.
    do_reset();
    rdy = 1'b0;
    repeat (4) send_sym(1'b1);
    chk("ovf_occ4", int'(o_occ), 4);
    chk("ovf_avail4", int'(o_avail), 4);
    chk("ovf_flag_before", int'(o_overflow), 0);
    send_sym(1'b0);
    chk("ovf_occ_after_drop", int'(o_occ), 4);
    chk("ovf_flag", int'(o_overflow), 1);
    chk("ovf_drop_cnt", int'(o_drop_cnt), 1);
    chk("ovf_wen_last", int'(o_wr_wen), 0);
    r0 = rises.size();
    rdy = 1'b1;
    wait_drain(120, "ovf_drain");
    chk("ovf_bursts", rises.size() - r0, 4);
    chk("ovf_avail0", int'(o_avail), 0);
    send_sym(1'b1);
    chk("ovf_new_commit_occ", int'(o_occ), 1);
    wait_drain(40, "ovf_drain2");
    chk("ovf_bursts_total", rises.size() - r0, 5);
    chk("ovf_flag_sticky", int'(o_overflow), 1);
    chk("ovf_drop_cnt_hold", int'(o_drop_cnt), 1);

    // Resync: a partial symbol is abandoned by a fresh sop.
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) send_word(i == 0, 1'b1);
    chk("rsy_partial_avail", int'(o_avail), 0);
    send_sym(1'b1);
    chk("rsy_avail", int'(o_avail), 1);
    chk("rsy_occ", int'(o_occ), 1);
    r0 = rises.size();
    rdy = 1'b1;
    wait_drain(40, "rsy_drain");
    repeat (20) tick();
    chk("rsy_bursts", rises.size() - r0, 1);
    chk("rsy_avail_end", int'(o_avail), 0);

    // Commit and launch on the same edge.
    do_reset();
    rdy = 1'b0;
    send_sym(1'b1);
    r0 = rises.size();
    for (int i = 0; i < SL - 1; i++) send_word(i == 0, 1'b1);
    rdy = 1'b1;
    send_word(1'b0, 1'b1);
    chk("sim_avail", int'(o_avail), 1);
    chk("sim_occ", int'(o_occ), 2);
    chk("sim_ren", int'(o_rd_ren), 1);
    wait_drain(60, "sim_drain");
    chk("sim_bursts", rises.size() - r0, 2);
    if (rises.size() >= r0 + 2)
      chk("sim_space", rises[r0 + 1] - rises[r0], SPACING);

    // Reset during a burst.
    do_reset();
    rdy = 1'b1;
    send_sym(1'b1);
    n = 0;
    while (!o_rd_ren && n < 10) begin
      tick();
      n++;
    end
    chk("rmr_started", int'(o_rd_ren), 1);
    repeat (3) tick();
    lc = last_cnt;
    rst = 1'b1;
    tick();
    chk_all_zero("rmr");
    rst = 1'b0;
    wq.delete();
    exp_addr = '0;
    repeat (20) tick();
    chk("rmr_no_last", last_cnt, lc);
    chk("rmr_ren_idle", int'(o_rd_ren), 0);

    chk("wq_empty", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_streams_sched.md
# mem_streams_sched

Write/read sequencer for the `mem_streams` multi-channel FIFO bank. It frames the incoming per-antenna sample stream into fixed-length symbols and drives the bank's shared write enable and write address. It tracks how many whole symbols are buffered and launches gap-separated, symbol-sized parallel read bursts when the downstream beam stage is ready. It sits between the PUSCH compression front end and `mem_streams`, and owns its `i_wr_wen`, `i_wr_addr`, `i_rd_ren` and `i_rvalid` inputs.

## Interface
- ADDR_WIDTH, 11: write address width; the FIFO bank holds 2^ADDR_WIDTH words per channel.
- SYM_LEN, 396: words per symbol; must satisfy 2 ≤ SYM_LEN ≤ 2^ADDR_WIDTH.
- GAP_CYC, 4: idle cycles forced after each read burst; 0 is allowed.
- Derived: MAX_SYM = floor(2^ADDR_WIDTH / SYM_LEN); CW = $clog2(MAX_SYM+1).
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_in_vld  in  1  one input word is present this cycle.
- i_in_sop  in  1  first word of a symbol; qualified by i_in_vld.
- i_rd_ready  in  1  downstream can accept one complete symbol burst.
- o_wr_wen  out  1  write enable to the bank.
- o_wr_addr  out  ADDR_WIDTH  write address to the bank.
- o_rd_ren  out  1  read enable to the bank.
- o_rvalid  out  1  read-window flag to the bank's i_rvalid.
- o_sym_last  out  1  one-cycle pulse on the last o_rd_ren cycle of a burst.
- o_avail  out  CW  symbols committed but not yet launched.
- o_occ  out  CW  symbols committed and not fully read out.
- o_overflow  out  1  sticky flag: at least one symbol was dropped.
- o_drop_cnt  out  16  count of dropped symbols; saturates at 16'hFFFF.

## Operation
- Write framing:
  - wcnt counts accepted i_in_vld words modulo SYM_LEN.
  - i_in_vld & i_in_sop forces this word to be word 0 and resyncs wcnt. A partial symbol in progress is discarded: it is not committed and its wr_addr advance is not rewound.
- Admission is decided at word 0 of each symbol:
  - Accept if o_occ < MAX_SYM.
  - Otherwise drop: all SYM_LEN words of the symbol are suppressed (no o_wr_wen, no address advance), o_overflow is set and o_drop_cnt increments once.
- Accepted word: o_wr_wen=1 and o_wr_addr=wr_addr on the next cycle; wr_addr then increments and wraps from 2^ADDR_WIDTH-1 to 0.
- Commit: when the word at wcnt==SYM_LEN-1 of an accepted symbol is written, o_avail and o_occ each increment by 1.
- Read FSM has three states: IDLE, READ, GAP.
  - IDLE→READ when o_avail>0 and i_rd_ready. o_avail decrements by 1 on this transition.
  - READ holds o_rd_ren=1 and o_rvalid=1 for exactly SYM_LEN cycles. i_rd_ready is ignored during READ.
  - On the last READ cycle, o_sym_last=1. o_occ decrements on the following cycle, and the FSM moves to GAP, or to IDLE if GAP_CYC=0.
  - GAP holds for GAP_CYC cycles with o_rd_ren=0 and o_rvalid=0, then returns to IDLE.
- Simultaneous commit and decrement on the same counter in the same cycle: the counter is unchanged.
- Underflow cannot occur: a read is launched only for a committed symbol.
- o_overflow clears only on reset.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and wr_addr, wcnt, avail and occ are 0.
- Reset mid-burst: the burst is abandoned the next cycle with no o_sym_last. The bank shares i_reset, so buffered data is discarded consistently.
- Write path: i_in_vld at cycle N gives o_wr_wen and o_wr_addr at N+1.
- Commit: the last word at cycle N gives o_wr_wen at N+1 and the o_avail/o_occ increment visible at N+1.
- Read launch: IDLE with o_avail>0 and i_rd_ready at cycle M gives o_rd_ren high for M+1 … M+SYM_LEN and o_sym_last at M+SYM_LEN.
  - Earliest launch after a commit: o_avail is visible at N+1, so M=N+1 and o_rd_ren rises at N+2.
- Minimum spacing between rising edges of back-to-back bursts is SYM_LEN+GAP_CYC+1 cycles.
- Bank latency (FIFO dout_valid gating of rd_ren) is absorbed by `mem_streams`; this block is oblivious to it.

## Test plan
Concrete values below use SYM_LEN=8, ADDR_WIDTH=5 (MAX_SYM=4) and GAP_CYC=2.
- Single symbol:
  - Stimulus: sop plus 8 contiguous i_in_vld words; i_rd_ready=1.
  - Required: o_wr_addr goes 0…7; o_avail=1 one cycle after the last write; o_rd_ren high for exactly 8 cycles starting 2 cycles after the last input word; o_sym_last on the 8th cycle; o_occ returns to 0.
- Back-to-back symbols:
  - Stimulus: 3 symbols with i_rd_ready=1.
  - Required: 3 bursts; rising edges spaced 11 cycles apart when input keeps pace.
- Overflow:
  - Stimulus: i_rd_ready=0 and 5 symbols.
  - Required: o_occ=4; the 5th symbol produces no o_wr_wen; o_overflow=1; o_drop_cnt=1; o_wr_addr wraps to 0 after 32 writes.
  - Follow-up: raise i_rd_ready; 4 bursts follow, then a new 6th symbol is accepted.
- Resync:
  - Stimulus: sop, 5 words, then sop and 8 words.
  - Required: exactly one commit; o_avail=1; the first partial symbol is never read.
- Simultaneous events:
  - Stimulus: a commit lands on the same cycle as an IDLE→READ launch with o_avail=1.
  - Required: o_avail stays 1 and a second burst follows after the gap.
- Reset mid-READ:
  - Stimulus: assert i_reset during a burst.
  - Required: the next cycle shows every output at 0 and no o_sym_last pulse.
